// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU-side SRAM-like bridges: transfer sizes,
// bridge FSM encoding and cache-line address alignment.
package cpu_axi_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWb   = 2'd1,
      StRf   = 2'd2
   } bridge_state_t;

   // Clear the byte-offset bits of a line address; line_words is a power of two.
   function automatic logic [31:0] line_align(input logic [31:0] addr,
                                              input int unsigned line_words);
      logic [31:0] span;
      span = line_words << 2;
      return addr & ~(span - 32'd1);
   endfunction

endpackage

// File: rtl/line_word_counter.sv
// Issue/response counter pair for one cache-line burst of word requests.
// Throttles issue so that no more than MAX_OUTSTANDING requests are in flight.
module line_word_counter #(
   parameter int unsigned LINE_WORDS      = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          clear,
   input  logic                          issue,
   input  logic                          resp,
   output logic [$clog2(LINE_WORDS):0]   issue_cnt,
   output logic [$clog2(LINE_WORDS):0]   resp_cnt,
   output logic                          can_issue,
   output logic                          last_resp
);

   localparam int unsigned CW = $clog2(LINE_WORDS) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

   logic [CW-1:0] issue_d;
   logic [CW-1:0] resp_d;
   logic [CW-1:0] outstanding;

   assign outstanding = issue_cnt - resp_cnt;
   assign can_issue   = (32'(issue_cnt) < LINE_WORDS) && (32'(outstanding) < MAX_OUTSTANDING);
   assign last_resp   = resp && (resp_cnt == LAST_IDX);

   // Next-state: clear wins; otherwise issue and response advance independently.
   always_comb begin
      issue_d = issue_cnt;
      resp_d  = resp_cnt;
      if (clear) begin
         issue_d = '0;
         resp_d  = '0;
      end else begin
         if (issue) issue_d = issue_cnt + CW'(1);
         if (resp)  resp_d  = resp_cnt + CW'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         issue_cnt <= '0;
         resp_cnt  <= '0;
      end else begin
         issue_cnt <= issue_d;
         resp_cnt  <= resp_d;
      end
   end

endmodule

// File: rtl/cache_line_sram_bridge.sv
// Turns dcache line refills and writebacks into word-sized SRAM-like requests,
// pipelining issue ahead of responses and streaming refill words back.
module cache_line_sram_bridge
   import cpu_axi_pkg::*;
#(
   parameter int unsigned LINE_WORDS      = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       rd_req,
   input  logic [31:0]                rd_addr,
   output logic                       rd_rdy,
   input  logic                       wr_req,
   input  logic [31:0]                wr_addr,
   input  logic [32*LINE_WORDS-1:0]   wr_data,
   output logic                       wr_rdy,
   output logic                       ret_valid,
   output logic                       ret_last,
   output logic [31:0]                ret_data,
   output logic                       wb_done,
   output logic                       data_req,
   output logic                       data_wr,
   output logic [1:0]                 data_size,
   output logic [31:0]                data_addr,
   output logic [3:0]                 data_wstrb,
   output logic [31:0]                data_wdata,
   input  logic                       data_addr_ok,
   input  logic                       data_data_ok,
   input  logic [31:0]                data_rdata
);

   localparam int unsigned CW = $clog2(LINE_WORDS) + 1;
   localparam int unsigned IW = $clog2(LINE_WORDS);

   bridge_state_t                 state_q, state_d;
   logic [31:0]                   base_q, base_d;
   logic [LINE_WORDS-1:0][31:0]   line_q, line_d;

   logic           clear;
   logic           issue;
   logic           resp;
   logic           can_issue;
   logic           last_resp;
   logic [CW-1:0]  issue_cnt;
   logic [CW-1:0]  resp_cnt;
   logic [IW-1:0]  word_idx;
   logic           idle;

   line_word_counter #(
      .LINE_WORDS      (LINE_WORDS),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_counter (
      .clk       (clk),
      .resetn    (resetn),
      .clear     (clear),
      .issue     (issue),
      .resp      (resp),
      .issue_cnt (issue_cnt),
      .resp_cnt  (resp_cnt),
      .can_issue (can_issue),
      .last_resp (last_resp)
   );

   assign idle     = (state_q == StIdle);
   assign issue    = data_req && data_addr_ok;
   // Responses outside a burst are protocol errors and must not move the counters.
   assign resp     = data_data_ok && !idle;
   assign word_idx = issue_cnt[IW-1:0];

   // Request side is a pure function of registered state, so it holds through stalls.
   assign data_req   = !idle && can_issue;
   assign data_wr    = (state_q == StWb);
   assign data_size  = SIZE_WORD;
   assign data_addr  = base_q + {{(32-CW-2){1'b0}}, issue_cnt, 2'b00};
   assign data_wstrb = data_wr ? 4'hf : 4'h0;
   assign data_wdata = line_q[word_idx];

   // Writeback takes priority over a simultaneous refill request.
   assign wr_rdy    = idle;
   assign rd_rdy    = idle && !wr_req;

   assign ret_valid = (state_q == StRf) && data_data_ok;
   assign ret_last  = (state_q == StRf) && last_resp;
   assign ret_data  = data_rdata;
   assign wb_done   = (state_q == StWb) && last_resp;

   // Next-state: accept a line operation in idle, leave on its final response.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      line_d  = line_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wr_req) begin
               state_d = StWb;
               base_d  = line_align(wr_addr, LINE_WORDS);
               line_d  = wr_data;
               clear   = 1'b1;
            end else if (rd_req) begin
               state_d = StRf;
               base_d  = line_align(rd_addr, LINE_WORDS);
               clear   = 1'b1;
            end
         end
         StWb, StRf: begin
            if (last_resp) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and latched line registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         base_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         line_q  <= line_d;
      end
   end

endmodule

// File: tb/tb_cache_line_sram_bridge.sv
// Directed bench for cache_line_sram_bridge: refill, stalled writeback,
// arbitration, outstanding limit, same-cycle issue/response and mid-burst reset.
module tb_cache_line_sram_bridge;

   logic          clk;
   logic          resetn;
   logic          rd_req, wr_req;
   logic [31:0]   rd_addr, wr_addr;
   logic [127:0]  wr_data;
   logic          rd_rdy, wr_rdy, ret_valid, ret_last, wb_done;
   logic [31:0]   ret_data;
   logic          data_req, data_wr;
   logic [1:0]    data_size;
   logic [31:0]   data_addr, data_wdata, data_rdata;
   logic [3:0]    data_wstrb;
   logic          data_addr_ok, data_data_ok;

   // Second instance with a shallow outstanding limit.
   logic          rd_req2, wr_req2;
   logic [31:0]   rd_addr2, wr_addr2;
   logic [127:0]  wr_data2;
   logic          rd_rdy2, wr_rdy2, ret_valid2, ret_last2, wb_done2;
   logic [31:0]   ret_data2;
   logic          data_req2, data_wr2;
   logic [1:0]    data_size2;
   logic [31:0]   data_addr2, data_wdata2, data_rdata2;
   logic [3:0]    data_wstrb2;
   logic          data_addr_ok2, data_data_ok2;

   int n_cmp;
   int n_err;

   // Per-operation log filled by run_op.
   logic [31:0] iss_addr [8];
   logic [31:0] iss_wdata [8];
   logic [31:0] ret_d [8];
   logic [7:0]  wr_mask;
   logic [3:0]  strb_or, strb_and;
   logic [7:0]  last_mask;
   int          n_iss, n_ret, n_resp, n_wbdone, wbdone_at;
   int          busy_rdy, spurious, hold_err, size_err, stall_seen;
   logic [31:0] pend_addr [$];
   int          pend_due [$];

   cache_line_sram_bridge #(
      .LINE_WORDS      (4),
      .MAX_OUTSTANDING (4)
   ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_rdy       (rd_rdy),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_rdy       (wr_rdy),
      .ret_valid    (ret_valid),
      .ret_last     (ret_last),
      .ret_data     (ret_data),
      .wb_done      (wb_done),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   cache_line_sram_bridge #(
      .LINE_WORDS      (4),
      .MAX_OUTSTANDING (2)
   ) u_dut2 (
      .clk          (clk),
      .resetn       (resetn),
      .rd_req       (rd_req2),
      .rd_addr      (rd_addr2),
      .rd_rdy       (rd_rdy2),
      .wr_req       (wr_req2),
      .wr_addr      (wr_addr2),
      .wr_data      (wr_data2),
      .wr_rdy       (wr_rdy2),
      .ret_valid    (ret_valid2),
      .ret_last     (ret_last2),
      .ret_data     (ret_data2),
      .wb_done      (wb_done2),
      .data_req     (data_req2),
      .data_wr      (data_wr2),
      .data_size    (data_size2),
      .data_addr    (data_addr2),
      .data_wstrb   (data_wstrb2),
      .data_wdata   (data_wdata2),
      .data_addr_ok (data_addr_ok2),
      .data_data_ok (data_data_ok2),
      .data_rdata   (data_rdata2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      n_iss = 0; n_ret = 0; n_resp = 0; n_wbdone = 0; wbdone_at = -1;
      busy_rdy = 0; spurious = 0; hold_err = 0; size_err = 0; stall_seen = 0;
      wr_mask = '0; strb_or = '0; strb_and = 4'hf; last_mask = '0;
      pend_addr.delete();
      pend_due.delete();
      for (int k = 0; k < 8; k++) begin
         iss_addr[k] = '0; iss_wdata[k] = '0; ret_d[k] = '0;
      end
   endtask

   // Called at posedge+1 in idle; leaves the bench at posedge+1 of the first busy cycle.
   task automatic accept_rd(input logic [31:0] addr);
      rd_req  = 1'b1;
      rd_addr = addr;
      #1;
      check_eq("rd accept rdy", 32'(rd_rdy), 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic accept_wr(input logic [31:0] addr, input logic [127:0] line);
      wr_req  = 1'b1;
      wr_addr = addr;
      wr_data = line;
      #1;
      check_eq("wr accept rdy", 32'(wr_rdy), 1);
      @(posedge clk); #1;
      wr_req = 1'b0;
   endtask

   // Downstream responder: returns each request's address as rdata, lat cycles after addr_ok.
   task automatic run_op(input int lat, input int stall_word, input int stall_len, input int budget);
      int          cyc;
      int          stall_left;
      bit          done;
      bit          holding;
      logic [31:0] held_a, held_d;
      cyc = 0; stall_left = stall_len; done = 1'b0; holding = 1'b0;
      held_a = '0; held_d = '0;
      while (!done && cyc < budget) begin
         data_data_ok = (pend_due.size() > 0) && (pend_due[0] <= cyc);
         data_rdata   = data_data_ok ? pend_addr[0] : 32'h0;
         data_addr_ok = !(n_iss == stall_word && stall_left > 0);
         #1;
         if (rd_rdy || wr_rdy) busy_rdy++;
         if (data_req) begin
            if (holding && (data_addr !== held_a || data_wdata !== held_d)) hold_err++;
            if (data_size !== 2'b10) size_err++;
         end
         if (data_req && !data_addr_ok) begin
            held_a = data_addr; held_d = data_wdata; holding = 1'b1;
            stall_left--; stall_seen++;
         end else if (data_req && data_addr_ok) begin
            holding = 1'b0;
            if (n_iss < 8) begin
               iss_addr[n_iss]  = data_addr;
               iss_wdata[n_iss] = data_wdata;
               wr_mask[n_iss]   = data_wr;
            end
            strb_or  = strb_or | data_wstrb;
            strb_and = strb_and & data_wstrb;
            pend_addr.push_back(data_addr);
            pend_due.push_back(cyc + lat);
            n_iss++;
         end
         if (data_data_ok) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            if (ret_valid && n_ret < 8) begin
               ret_d[n_ret] = ret_data;
               if (ret_last) last_mask[n_ret] = 1'b1;
               n_ret++;
            end
            if (wb_done) begin
               n_wbdone++;
               wbdone_at = n_resp;
            end
            n_resp++;
            if (n_resp == 4) done = 1'b1;
         end else if (ret_valid || ret_last || wb_done) begin
            spurious++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      data_data_ok = 1'b0;
      data_addr_ok = 1'b0;
      data_rdata   = '0;
      check_eq("op completes", 32'(done), 1);
   endtask

   task automatic check_rf(input string tag, input logic [31:0] base);
      check_eq({tag, " issued"}, 32'(n_iss), 4);
      check_eq({tag, " returned"}, 32'(n_ret), 4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("%s addr%0d", tag, k), iss_addr[k], base + 32'(4 * k));
         check_eq($sformatf("%s ret%0d", tag, k), ret_d[k], base + 32'(4 * k));
      end
      check_eq({tag, " last only word3"}, 32'(last_mask), 32'h08);
      check_eq({tag, " data_wr"}, 32'(wr_mask), 0);
      check_eq({tag, " wstrb"}, 32'(strb_or), 0);
      check_eq({tag, " size"}, 32'(size_err), 0);
      check_eq({tag, " rdy while busy"}, 32'(busy_rdy), 0);
      check_eq({tag, " spurious out"}, 32'(spurious), 0);
      check_eq({tag, " wb_done"}, 32'(n_wbdone), 0);
   endtask

   task automatic check_wb(input string tag, input logic [31:0] base, input logic [127:0] line);
      logic [127:0] l;
      l = line;
      check_eq({tag, " issued"}, 32'(n_iss), 4);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("%s addr%0d", tag, k), iss_addr[k], base + 32'(4 * k));
         check_eq($sformatf("%s wdata%0d", tag, k), iss_wdata[k], l[32*k +: 32]);
      end
      check_eq({tag, " data_wr"}, 32'(wr_mask), 32'h0f);
      check_eq({tag, " wstrb"}, 32'(strb_and), 32'hf);
      check_eq({tag, " wb_done count"}, 32'(n_wbdone), 1);
      check_eq({tag, " wb_done on 4th"}, 32'(wbdone_at), 3);
      check_eq({tag, " no ret"}, 32'(n_ret), 0);
      check_eq({tag, " rdy while busy"}, 32'(busy_rdy), 0);
      check_eq({tag, " spurious out"}, 32'(spurious), 0);
      check_eq({tag, " hold"}, 32'(hold_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nq;
      n_cmp = 0; n_err = 0;
      resetn = 1'b0;
      rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
      rd_req2 = 0; wr_req2 = 0; rd_addr2 = '0; wr_addr2 = '0; wr_data2 = '0;
      data_addr_ok2 = 0; data_data_ok2 = 0; data_rdata2 = '0;
      clear_log();
      #1;
      check_eq("rst data_req", 32'(data_req), 0);
      check_eq("rst ret_valid", 32'(ret_valid), 0);
      check_eq("rst ret_last", 32'(ret_last), 0);
      check_eq("rst wb_done", 32'(wb_done), 0);
      check_eq("rst rd_rdy", 32'(rd_rdy), 1);
      check_eq("rst wr_rdy", 32'(wr_rdy), 1);
      check_eq("rst wstrb", 32'(data_wstrb), 0);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // Plain refill; latency 2 also lands word 2's addr_ok on word 0's data_ok.
      clear_log();
      accept_rd(32'h1000_0034);
      run_op(2, -1, 0, 60);
      check_rf("rf1", 32'h1000_0030);
      #1;
      check_eq("rf1 rd_rdy after", 32'(rd_rdy), 1);
      check_eq("rf1 data_req after", 32'(data_req), 0);
      @(posedge clk); #1;

      // Writeback with a three-cycle addr_ok stall on word 1.
      clear_log();
      accept_wr(32'h2000_0000, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA});
      run_op(2, 1, 3, 60);
      check_wb("wb1", 32'h2000_0000, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA});
      check_eq("wb1 stall cycles", 32'(stall_seen), 3);
      @(posedge clk); #1;

      // Simultaneous requests: writeback first, held refill taken right after wb_done.
      clear_log();
      rd_req = 1'b1; rd_addr = 32'h3000_0008;
      wr_req = 1'b1; wr_addr = 32'h3100_0004;
      wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      #1;
      check_eq("arb rd_rdy", 32'(rd_rdy), 0);
      check_eq("arb wr_rdy", 32'(wr_rdy), 1);
      @(posedge clk); #1;
      wr_req = 1'b0;
      run_op(2, -1, 0, 60);
      check_wb("arb wb", 32'h3100_0000, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
      #1;
      check_eq("arb b2b rd_rdy", 32'(rd_rdy), 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
      clear_log();
      run_op(2, -1, 0, 60);
      check_rf("arb rf", 32'h3000_0000);
      @(posedge clk); #1;

      // Back-to-back responses every cycle.
      clear_log();
      accept_rd(32'h5000_001C);
      run_op(1, -1, 0, 40);
      check_rf("rf lat1", 32'h5000_0010);
      @(posedge clk); #1;

      // Outstanding limit of 2 on the second instance.
      rd_req2 = 1'b1; rd_addr2 = 32'h4000_0000;
      @(posedge clk); #1;
      rd_req2 = 1'b0;
      data_addr_ok2 = 1'b1;
      nq = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (data_req2 && data_addr_ok2) nq++;
         @(posedge clk); #1;
      end
      #1;
      check_eq("max2 issued", 32'(nq), 2);
      check_eq("max2 req low", 32'(data_req2), 0);
      data_data_ok2 = 1'b1; data_rdata2 = 32'h4000_0000;
      #1;
      check_eq("max2 ret_valid", 32'(ret_valid2), 1);
      check_eq("max2 ret_data", ret_data2, 32'h4000_0000);
      @(posedge clk); #1;
      data_data_ok2 = 1'b0; data_addr_ok2 = 1'b0;
      #1;
      check_eq("max2 req again", 32'(data_req2), 1);
      check_eq("max2 next addr", data_addr2, 32'h4000_0008);

      // Reset in the middle of a refill after two issues.
      @(posedge clk); #1;
      clear_log();
      accept_rd(32'h6000_0000);
      data_addr_ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         @(posedge clk); #1;
      end
      #1;
      check_eq("pre-reset data_req", 32'(data_req), 1);
      check_eq("pre-reset addr", data_addr, 32'h6000_0008);
      resetn = 1'b0;
      data_data_ok = 1'b1; data_rdata = 32'h6000_0000;
      #1;
      check_eq("reset data_req", 32'(data_req), 0);
      check_eq("reset ret_valid", 32'(ret_valid), 0);
      check_eq("reset rd_rdy", 32'(rd_rdy), 1);
      @(posedge clk); #1;
      resetn = 1'b1;
      data_data_ok = 1'b0; data_addr_ok = 1'b0; data_rdata = '0;
      #1;
      check_eq("post-reset rd_rdy", 32'(rd_rdy), 1);
      check_eq("post-reset data_req", 32'(data_req), 0);
      @(posedge clk); #1;
      clear_log();
      accept_rd(32'h7000_0014);
      run_op(3, -1, 0, 60);
      check_rf("rf after reset", 32'h7000_0010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
